// File: rtl/data_memory_pkg.sv
// Shared constants, word type and preload helpers for the MEM-stage data memory.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package data_memory_pkg;

    localparam int WORD_W    = 16;
    localparam int ADDR_BITS = 8;
    localparam int DEPTH     = 2 ** ADDR_BITS;
    localparam int INIT_BASE = 5;

    typedef logic [WORD_W-1:0]             word_t;
    typedef logic [ADDR_BITS-1:0]          idx_t;
    // Whole array as one packed image so it can be assigned in a single step.
    typedef logic [DEPTH-1:0][WORD_W-1:0]  mem_t;

    // Preload value of word i: INIT_BASE + i, wrapped to the word width.
    function automatic word_t init_word(input int i);
        return word_t'(INIT_BASE + i);
    endfunction

    // Full preload image, used both at power-up and on reset.
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = init_word(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory for the 16-bit MIPS datapath (MEM stage).
// Latency: combinational read (0 cycles); write lands on the next rising clk edge.
// Backpressure: none; every access completes immediately, no wait states.
module data_memory
    import data_memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] write_data,
    output logic [WORD_W-1:0] read_data
);

    // Storage starts out holding the same pattern a reset restores, so a
    // design that never asserts rst still sees the documented contents.
    mem_t mem = init_mem();

    idx_t idx;

    // Upper address bits alias onto the low index; memRead is kept only for
    // interface compatibility with the control unit and has no effect.
    logic unused_bits;

    assign idx         = address[ADDR_BITS-1:0];
    assign unused_bits = ^{memRead, address[WORD_W-1:ADDR_BITS]};

    // Reset restores the preload image (dropping any same-cycle write);
    // otherwise a full-word write is stored at the indexed location.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= init_mem();
        end else if (memWrite) begin
            mem[idx] <= write_data;
        end
    end

    // Read is asynchronous and never gated, so a write is visible right after its edge.
    assign read_data = mem[idx];

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
    import data_memory_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] write_data = '0;
    logic [15:0] read_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [DEPTH];

    data_memory dut (
        .clk        (clk),
        .rst        (rst),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait for the next rising edge, then move 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set an address and look at the combinational read a moment later.
    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        address = a;
        #1;
        chk(tag, read_data, exp);
    endtask

    initial begin
        // 1: power-up contents without any reset
        #100;
        chk("powerup_0", read_data, 16'd5);
        rd("powerup_255", 16'd255, 16'd260);
        rd("powerup_20", 16'd20, 16'd25);

        // 2: basic write then read back
        step();
        address = 16'd20; write_data = 16'd15; memWrite = 1'b1;
        step();
        memWrite = 1'b0; memRead = 1'b1;
        #1;
        chk("write_20", read_data, 16'd15);
        rd("neighbour_21", 16'd21, 16'd26);

        // 3: aliasing of upper address bits
        address = 16'h0103; write_data = 16'hBEEF; memWrite = 1'b1;
        step();
        memWrite = 1'b0;
        rd("alias_3", 16'd3, 16'hBEEF);
        rd("alias_ff03", 16'hFF03, 16'hBEEF);
        rd("alias_4_untouched", 16'd4, 16'd9);

        // 4: simultaneous read and write
        memRead = 1'b1; memWrite = 1'b1; address = 16'd7; write_data = 16'h1234;
        #1;
        chk("rw_before_edge", read_data, 16'd12);
        step();
        chk("rw_after_edge", read_data, 16'h1234);
        memWrite = 1'b0;

        // 5: reset restores preload and drops the same-cycle write
        rst = 1'b1; memWrite = 1'b1; write_data = 16'h0000; address = 16'd20;
        step();
        rst = 1'b0; memWrite = 1'b0;
        #1;
        chk("reset_20", read_data, 16'd25);
        rd("reset_3", 16'd3, 16'd8);
        rd("reset_7", 16'd7, 16'd12);
        rd("reset_alias_0103", 16'h0103, 16'd8);

        // Scoreboard starts from the preload image, then takes two writes.
        for (int i = 0; i < DEPTH; i++) model[i] = 16'(INIT_BASE + i);
        address = 16'd200; write_data = 16'hA5A5; memWrite = 1'b1;
        step();
        model[200] = 16'hA5A5;
        address = 16'h0301; write_data = 16'h5A5A;
        step();
        model[1] = 16'h5A5A;
        memWrite = 1'b0;
        rd("sb_write_200", 16'd200, 16'hA5A5);
        rd("sb_write_1", 16'd1, 16'h5A5A);

        // 6: memWrite low with toggling inputs must leave the array alone
        for (int c = 0; c < 10; c++) begin
            logic [15:0] a;
            a = (c % 3 == 0) ? 16'd200 : ((c % 3 == 1) ? 16'h0301 : 16'($urandom));
            address    = a;
            write_data = 16'($urandom);
            memRead    = c[0];
            #1;
            chk("hold_read", read_data, model[a[7:0]]);
            step();
            chk("hold_after_edge", read_data, model[a[7:0]]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
